// File: rtl/tank_motion_ctrl_if.sv
// Tank controller bus: held key levels and fire ack in, position/facing/state and fire request out.
// master = keyboard/bullet side that drives keys and ack, slave = the motion controller.
interface tank_motion_ctrl_if;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       fire;
    logic       fire_ack;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [1:0] direction;
    logic [1:0] state;
    logic       fire_req;
    logic [1:0] fire_dir;

    modport master (
        output up, down, left, right, fire, fire_ack,
        input  pos_x, pos_y, direction, state, fire_req, fire_dir
    );

    modport slave (
        input  up, down, left, right, fire, fire_ack,
        output pos_x, pos_y, direction, state, fire_req, fire_dir
    );
endinterface

// File: rtl/tank_motion_ctrl.sv
// Tank motion/fire controller: tick-paced, saturating position update with key priority and a
// req/ack fire request. Optional macro TANK_TURN_STALL_EN spends one tick in TURNING on a turn.
module tank_motion_ctrl #(
    parameter int         TICK_DIV = 50000,
    parameter int         SPEED    = 1,
    parameter int         X_MIN    = 0,
    parameter int         X_MAX    = 608,
    parameter int         Y_MIN    = 0,
    parameter int         Y_MAX    = 448,
    parameter int         INIT_X   = 250,
    parameter int         INIT_Y   = 150,
    parameter logic [1:0] INIT_DIR = 2'd0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    tank_motion_ctrl_if.slave  bus
);
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_STILL   = 2'd0,
        ST_MOVING  = 2'd1,
        ST_TURNING = 2'd2
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;

    logic [CW-1:0] r_cnt;
    logic [4:0]    r_k;        // {fire, right, left, down, up}
    logic          r_fire_d;
    logic [9:0]    r_pos_x;
    logic [9:0]    r_pos_y;
    logic [1:0]    r_dir;
    state_t        r_state;
    logic          r_fire_req;
    logic [1:0]    r_fire_dir;

    logic          w_tick;
    logic          w_key_vld;
    logic [1:0]    w_key_dir;
    logic          w_step;
    logic [9:0]    w_dec_x, w_inc_x, w_dec_y, w_inc_y;
    logic [9:0]    w_pos_x_nx, w_pos_y_nx;
    logic [1:0]    w_dir_nx;
    state_t        w_state_nx;
    logic          w_fire_rise;

    assign w_tick      = (r_cnt == CW'(TICK_DIV - 1));
    assign w_key_vld   = |r_k[3:0];
    assign w_fire_rise = r_k[4] & ~r_fire_d;

    always_comb begin
        w_key_dir = 2'd3;
        if (r_k[0])      w_key_dir = DIR_UP;
        else if (r_k[1]) w_key_dir = DIR_DOWN;
        else if (r_k[2]) w_key_dir = DIR_LEFT;
    end

    // Saturating steps: compare in int so MIN+SPEED / MAX-SPEED never wrap the 10-bit range.
    assign w_dec_x = (int'(r_pos_x) >= X_MIN + SPEED) ? r_pos_x - 10'(SPEED) : 10'(X_MIN);
    assign w_inc_x = (int'(r_pos_x) <= X_MAX - SPEED) ? r_pos_x + 10'(SPEED) : 10'(X_MAX);
    assign w_dec_y = (int'(r_pos_y) >= Y_MIN + SPEED) ? r_pos_y - 10'(SPEED) : 10'(Y_MIN);
    assign w_inc_y = (int'(r_pos_y) <= Y_MAX - SPEED) ? r_pos_y + 10'(SPEED) : 10'(Y_MAX);

    always_comb begin
        w_state_nx = r_state;
        w_dir_nx   = r_dir;
        w_step     = 1'b0;
        w_pos_x_nx = r_pos_x;
        w_pos_y_nx = r_pos_y;
        if (w_tick) begin
            if (!w_key_vld) begin
                w_state_nx = ST_STILL;
            end else if (w_key_dir == r_dir) begin
                w_state_nx = ST_MOVING;
                w_step     = 1'b1;
            end else begin
                w_dir_nx   = w_key_dir;
`ifdef TANK_TURN_STALL_EN
                w_state_nx = ST_TURNING;
`else
                w_state_nx = ST_MOVING;
                w_step     = 1'b1;
`endif
            end
        end
        if (w_step) begin
            case (w_key_dir)
                DIR_UP:   w_pos_y_nx = w_dec_y;
                DIR_DOWN: w_pos_y_nx = w_inc_y;
                DIR_LEFT: w_pos_x_nx = w_dec_x;
                default:  w_pos_x_nx = w_inc_x;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_k      <= '0;
            r_fire_d <= 1'b0;
            r_pos_x  <= 10'(INIT_X);
            r_pos_y  <= 10'(INIT_Y);
            r_dir    <= INIT_DIR;
            r_state  <= ST_STILL;
        end else begin
            r_cnt    <= w_tick ? '0 : r_cnt + 1'b1;
            r_k      <= {bus.fire, bus.right, bus.left, bus.down, bus.up};
            r_fire_d <= r_k[4];
            r_pos_x  <= w_pos_x_nx;
            r_pos_y  <= w_pos_y_nx;
            r_dir    <= w_dir_nx;
            r_state  <= w_state_nx;
        end
    end

    // An edge arriving with the ack is dropped because the request is still up that cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fire_req <= 1'b0;
            r_fire_dir <= 2'd0;
        end else if (r_fire_req) begin
            if (bus.fire_ack) r_fire_req <= 1'b0;
        end else if (w_fire_rise) begin
            r_fire_req <= 1'b1;
            r_fire_dir <= r_dir;
        end
    end

    assign bus.pos_x     = r_pos_x;
    assign bus.pos_y     = r_pos_y;
    assign bus.direction = r_dir;
    assign bus.state     = r_state;
    assign bus.fire_req  = r_fire_req;
    assign bus.fire_dir  = r_fire_dir;
endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Bench for tank_motion_ctrl at TICK_DIV=4: cycle model compared every cycle plus directed
// literal expectations from the motion/fire rules.
module tb_tank_motion_ctrl;
    localparam int TD = 4;
`ifdef TANK_TURN_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    tank_motion_ctrl_if bus ();

    tank_motion_ctrl #(.TICK_DIV(TD)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: positions as plain ints, ticks counted from reset by cycle number.
    bit m_valid = 1'b0;
    int m_x, m_y, m_dir, m_st, m_cyc, m_ticks;
    bit m_req;
    int m_fdir;
    bit ku, kd, kl, kr, kf, m_fprev;
    int nx, ny, nd, ns, kdir;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_x <= 250; m_y <= 150; m_dir <= 0; m_st <= 0;
            m_cyc <= 0; m_ticks <= 0;
            m_req <= 1'b0; m_fdir <= 0;
            {ku, kd, kl, kr, kf, m_fprev} <= '0;
        end else if (m_valid) begin
            nx = m_x; ny = m_y; nd = m_dir; ns = m_st;
            if (m_cyc % TD == TD - 1) begin
                if (!(ku || kd || kl || kr)) begin
                    ns = 0;
                end else begin
                    kdir = ku ? 0 : kd ? 1 : kl ? 2 : 3;
                    nd = kdir;
                    if (kdir != m_dir && STALL) begin
                        ns = 2;
                    end else begin
                        ns = 1;
                        case (kdir)
                            0: ny = (ny - 1 < 0)   ? 0   : ny - 1;
                            1: ny = (ny + 1 > 448) ? 448 : ny + 1;
                            2: nx = (nx - 1 < 0)   ? 0   : nx - 1;
                            default: nx = (nx + 1 > 608) ? 608 : nx + 1;
                        endcase
                    end
                end
                m_ticks <= m_ticks + 1;
            end
            m_x <= nx; m_y <= ny; m_dir <= nd; m_st <= ns;
            if (m_req) begin
                if (bus.fire_ack) m_req <= 1'b0;
            end else if (kf && !m_fprev) begin
                m_req  <= 1'b1;
                m_fdir <= m_dir;
            end
            m_fprev <= kf;
            ku <= bus.up; kd <= bus.down; kl <= bus.left; kr <= bus.right; kf <= bus.fire;
            m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pos_x",     int'(bus.pos_x),     m_x);
            chk("pos_y",     int'(bus.pos_y),     m_y);
            chk("direction", int'(bus.direction), m_dir);
            chk("state",     int'(bus.state),     m_st);
            chk("fire_req",  int'(bus.fire_req),  int'(m_req));
            if (m_req) chk("fire_dir", int'(bus.fire_dir), m_fdir);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        int target;
        int guard;
        target = m_ticks + n;
        guard  = 0;
        while (m_ticks < target && guard < (n + 1) * TD + 2) begin
            @(negedge clk);
            guard++;
        end
        chk("tick_wait", int'(m_ticks >= target), 1);
    endtask

    task automatic fire_press();
        bus.fire = 1'b1; cyc(1);
        bus.fire = 1'b0; cyc(1);
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        {bus.up, bus.down, bus.left, bus.right, bus.fire, bus.fire_ack} = '0;
        cyc(2);
        rst = 1'b0;
        chk("rst_x", int'(bus.pos_x), 250);
        chk("rst_y", int'(bus.pos_y), 150);
        chk("rst_dir", int'(bus.direction), 0);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_req", int'(bus.fire_req), 0);
        wait_ticks(1);
        chk("idle_y", int'(bus.pos_y), 150);

        // hold up for three ticks
        bus.up = 1'b1; cyc(1);
        wait_ticks(3);
        chk("up3_y", int'(bus.pos_y), 147);
        chk("up3_x", int'(bus.pos_x), 250);
        chk("up3_state", int'(bus.state), 1);
        bus.up = 1'b0; cyc(1);
        wait_ticks(1);
        chk("rel_state", int'(bus.state), 0);

        // up+down+left: only up acts
        bus.up = 1'b1; bus.down = 1'b1; bus.left = 1'b1; cyc(1);
        wait_ticks(2);
        chk("prio_y", int'(bus.pos_y), 145);
        chk("prio_x", int'(bus.pos_x), 250);
        chk("prio_dir", int'(bus.direction), 0);
        {bus.up, bus.down, bus.left} = '0; cyc(1);

        // fire handshake
        fire_press();
        chk("fire_req1", int'(bus.fire_req), 1);
        chk("fire_dir1", int'(bus.fire_dir), 0);
        cyc(10);
        chk("fire_hold", int'(bus.fire_req), 1);
        bus.fire = 1'b1; cyc(2); bus.fire = 1'b0; cyc(2);
        chk("fire_ignored", int'(bus.fire_req), 1);
        bus.fire_ack = 1'b1; cyc(1); bus.fire_ack = 1'b0;
        chk("fire_acked", int'(bus.fire_req), 0);
        bus.fire_ack = 1'b1; cyc(2); bus.fire_ack = 1'b0;
        chk("stray_ack", int'(bus.fire_req), 0);
        fire_press();
        chk("fire_req2", int'(bus.fire_req), 1);
        bus.fire_ack = 1'b1; cyc(1); bus.fire_ack = 1'b0;

        // turn right from UP
        bus.right = 1'b1; cyc(1);
        wait_ticks(1);
        chk("turn_dir", int'(bus.direction), 3);
        chk("turn_x1", int'(bus.pos_x), STALL ? 250 : 251);
        chk("turn_state", int'(bus.state), STALL ? 2 : 1);
        wait_ticks(1);
        chk("turn_x2", int'(bus.pos_x), STALL ? 251 : 252);
        fire_press();
        chk("fire_dir_r", int'(bus.fire_dir), 3);
        bus.fire_ack = 1'b1; cyc(1); bus.fire_ack = 1'b0;

        // run to the right edge and push against it
        guard = 0;
        while (m_x != 607 && guard < 3000) begin cyc(1); guard++; end
        chk("reach_607", int'(bus.pos_x), 607);
        for (int i = 0; i < 3; i++) begin
            wait_ticks(1);
            chk("edge_x", int'(bus.pos_x), 608);
            chk("edge_state", int'(bus.state), 1);
        end

        // run to the top edge, no wrap
        bus.right = 1'b0; bus.up = 1'b1;
        guard = 0;
        while (m_y != 0 && guard < 3000) begin cyc(1); guard++; end
        chk("reach_y0", int'(bus.pos_y), 0);
        wait_ticks(2);
        chk("top_y", int'(bus.pos_y), 0);
        chk("top_state", int'(bus.state), 1);
        bus.up = 1'b0; cyc(1);

        // reset while a request is pending
        fire_press();
        chk("fire_req3", int'(bus.fire_req), 1);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("rst_drop_req", int'(bus.fire_req), 0);
        chk("rst2_x", int'(bus.pos_x), 250);
        cyc(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
